// File: rtl/id_ex_operand_stage_pkg.sv
// pipe_pkg: shared constants and types for the ID/EX operand stage.
//   XLEN, REG_AW : operand and register-index widths
//   REG_X0       : index of the hard-wired zero register
//   fwd_sel_e    : operand source chosen by the hazard/forwarding unit
//   idex_t       : contents of the ID/EX pipeline register
package pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              is_load;
    } idex_t;

endpackage

// File: rtl/id_ex_operand_stage_hazard_fwd.sv
// hazard_fwd_unit: combinational forwarding select and hazard detect for one
// source operand of the instruction in ID.
//   src_idx/src_used/id_valid        : the ID source operand being resolved
//   ex_valid/ex_wen/ex_rd/ex_is_load : producer held in the ID/EX register
//   mem_wen/mem_rd/mem_is_load       : producer in MEM
//   wb_wen/wb_rd                     : producer in WB
//   fwd_sel                          : which value feeds the operand
//   hazard                           : operand cannot be supplied this cycle
// Build option: RF_BYPASS_EN forwards WB data instead of stalling on a WB match.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src_idx,
    input  logic              src_used,
    input  logic              id_valid,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_is_load,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_e          fwd_sel,
    output logic              hazard
);

    logic raw_hazard;

    // Checks run youngest producer first, so the first match decides both the
    // forwarded value and whether it is usable (a load result is not yet).
    always_comb begin
        fwd_sel    = FWD_RF;
        raw_hazard = 1'b0;
        if (src_idx == REG_X0) begin
            fwd_sel = FWD_ZERO;
        end else if (ex_valid && ex_wen && (ex_rd == src_idx)) begin
            fwd_sel    = FWD_EX;
            raw_hazard = ex_is_load;
        end else if (mem_wen && (mem_rd == src_idx)) begin
            fwd_sel    = FWD_MEM;
            raw_hazard = mem_is_load;
        end else if (wb_wen && (wb_rd == src_idx)) begin
`ifdef RF_BYPASS_EN
            fwd_sel    = FWD_WB;
`else
            // RF is written at this edge; retrying next cycle reads the new value.
            fwd_sel    = FWD_RF;
            raw_hazard = 1'b1;
`endif
        end
    end

    assign hazard = id_valid & src_used & raw_hazard;

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: RV32I decode-side operand stage. Drives RF read
// addresses, forwards from EX/MEM/WB, detects load-use hazards, and owns the
// ID/EX pipeline register (valid/ready, stall, flush).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   id_*                : instruction in ID
//   rf_rs*_addr/value   : register-file read port (async read)
//   ex_alu_result       : result of the instruction in EX
//   mem_*, wb_*         : later-stage producers
//   ex_ready, flush     : EX handshake and branch kill
//   stall_id            : hold PC and IF/ID
//   ex_*                : ID/EX register outputs
//   stall_cnt           : saturating count of hazard-stall cycles
// Build option: RF_BYPASS_EN (WB data forwarded rather than stalled on).
module id_ex_operand_stage
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    output logic [REG_AW-1:0] rf_rs1_addr,
    output logic [REG_AW-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_value,
    input  logic [XLEN-1:0]   rf_rs2_value,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_is_load,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wen,
    output logic              ex_is_load,
    output logic [31:0]       stall_cnt
);

    idex_t           idex_q;
    fwd_sel_e        sel1;
    fwd_sel_e        sel2;
    logic            haz1;
    logic            haz2;
    logic            hazard;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign rf_rs1_addr = id_rs1;
    assign rf_rs2_addr = id_rs2;

    hazard_fwd_unit u_fwd_rs1 (
        .src_idx    (id_rs1),
        .src_used   (id_rs1_used),
        .id_valid   (id_valid),
        .ex_valid   (idex_q.valid),
        .ex_wen     (idex_q.wen),
        .ex_rd      (idex_q.rd),
        .ex_is_load (idex_q.is_load),
        .mem_wen    (mem_wen),
        .mem_rd     (mem_rd),
        .mem_is_load(mem_is_load),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .fwd_sel    (sel1),
        .hazard     (haz1)
    );

    hazard_fwd_unit u_fwd_rs2 (
        .src_idx    (id_rs2),
        .src_used   (id_rs2_used),
        .id_valid   (id_valid),
        .ex_valid   (idex_q.valid),
        .ex_wen     (idex_q.wen),
        .ex_rd      (idex_q.rd),
        .ex_is_load (idex_q.is_load),
        .mem_wen    (mem_wen),
        .mem_rd     (mem_rd),
        .mem_is_load(mem_is_load),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .fwd_sel    (sel2),
        .hazard     (haz2)
    );

    assign hazard = haz1 | haz2;

    always_comb begin
        op1 = rf_rs1_value;
        case (sel1)
            FWD_ZERO: op1 = '0;
            FWD_EX:   op1 = ex_alu_result;
            FWD_MEM:  op1 = mem_result;
            FWD_WB:   op1 = wb_data;
            default:  op1 = rf_rs1_value;
        endcase
    end

    always_comb begin
        op2 = rf_rs2_value;
        case (sel2)
            FWD_ZERO: op2 = '0;
            FWD_EX:   op2 = ex_alu_result;
            FWD_MEM:  op2 = mem_result;
            FWD_WB:   op2 = wb_data;
            default:  op2 = rf_rs2_value;
        endcase
    end

    // Flush drops the wrong-path ID instruction, so IF must not be held.
    assign stall_id = ~flush & (~ex_ready | hazard);

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q.valid   <= 1'b0;
            idex_q.wen     <= 1'b0;
            idex_q.is_load <= 1'b0;
        end else if (!ex_ready) begin
            idex_q <= idex_q;
        end else if (hazard) begin
            idex_q.valid   <= 1'b0;
            idex_q.wen     <= 1'b0;
            idex_q.is_load <= 1'b0;
        end else begin
            idex_q.valid   <= id_valid;
            idex_q.pc      <= id_pc;
            idex_q.imm     <= id_imm;
            idex_q.rs1_val <= op1;
            idex_q.rs2_val <= op2;
            idex_q.rd      <= id_rd;
            idex_q.wen     <= id_valid & id_wen;
            idex_q.is_load <= id_valid & id_is_load;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && ex_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ex_valid   = idex_q.valid;
    assign ex_pc      = idex_q.pc;
    assign ex_imm     = idex_q.imm;
    assign ex_rs1_val = idex_q.rs1_val;
    assign ex_rs2_val = idex_q.rs2_val;
    assign ex_rd      = idex_q.rd;
    assign ex_wen     = idex_q.wen;
    assign ex_is_load = idex_q.is_load;

endmodule
